// File: rtl/nou_req_pkg.sv
// Shared types for the NOU request queue: channel enum, request layouts,
// payload width and pack/unpack helpers used by the decoder and engines.
package nou_req_pkg;

    localparam int NOU_SID_WIDTH  = 8;
    localparam int NOU_REQ_NUM_CH = 5;

    typedef enum logic [2:0] {
        CH_IRR   = 3'd0,
        CH_BRR   = 3'd1,
        CH_PWRR  = 3'd2,
        CH_SPIDR = 3'd3,
        CH_SPRR  = 3'd4
    } nou_req_ch_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] len;
    } irr_req_t;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] size;
        logic [31:0] flags;
    } brr_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
    } pwrr_req_t;

    typedef struct packed {
        logic [15:0] id;
    } spidr_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } sprr_req_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Payload width is the widest request layout.
    localparam int NOU_REQ_DATA_W =
        max2(max2(max2($bits(irr_req_t), $bits(brr_req_t)),
                  max2($bits(pwrr_req_t), $bits(spidr_req_t))),
             $bits(sprr_req_t));

    typedef logic [NOU_REQ_DATA_W-1:0] nou_req_data_t;

    function automatic nou_req_data_t pack_irr(input irr_req_t r);
        return NOU_REQ_DATA_W'(r);
    endfunction

    function automatic irr_req_t unpack_irr(input nou_req_data_t d);
        return irr_req_t'(d[$bits(irr_req_t)-1:0]);
    endfunction

    function automatic nou_req_data_t pack_brr(input brr_req_t r);
        return NOU_REQ_DATA_W'(r);
    endfunction

    function automatic brr_req_t unpack_brr(input nou_req_data_t d);
        return brr_req_t'(d[$bits(brr_req_t)-1:0]);
    endfunction

    function automatic nou_req_data_t pack_pwrr(input pwrr_req_t r);
        return NOU_REQ_DATA_W'(r);
    endfunction

    function automatic pwrr_req_t unpack_pwrr(input nou_req_data_t d);
        return pwrr_req_t'(d[$bits(pwrr_req_t)-1:0]);
    endfunction

    function automatic nou_req_data_t pack_spidr(input spidr_req_t r);
        return NOU_REQ_DATA_W'(r);
    endfunction

    function automatic spidr_req_t unpack_spidr(input nou_req_data_t d);
        return spidr_req_t'(d[$bits(spidr_req_t)-1:0]);
    endfunction

    function automatic nou_req_data_t pack_sprr(input sprr_req_t r);
        return NOU_REQ_DATA_W'(r);
    endfunction

    function automatic sprr_req_t unpack_sprr(input nou_req_data_t d);
        return sprr_req_t'(d[$bits(sprr_req_t)-1:0]);
    endfunction

endpackage

// File: rtl/nou_req_queue_if.sv
// Request queue bus: per-channel valid/ready inputs, merged output stream
// and occupancy. slave = queue side, master = decoder/execution side.
interface nou_req_queue_if
    import nou_req_pkg::*;
#(
    parameter int NUM_CH = NOU_REQ_NUM_CH,
    parameter int DATA_W = NOU_REQ_DATA_W,
    parameter int SID_W  = NOU_SID_WIDTH,
    parameter int DEPTH  = 2
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNW = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]        in_vld;
    logic [NUM_CH-1:0]        in_rdy;
    logic [NUM_CH*SID_W-1:0]  in_sid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        flush;
    logic                     out_vld;
    logic                     out_rdy;
    logic [CHW-1:0]           out_ch;
    logic [SID_W-1:0]         out_sid;
    logic [DATA_W-1:0]        out_data;
    logic [NUM_CH*CNW-1:0]    cnt;

    modport slave (
        input  in_vld, in_sid, in_data, flush, out_rdy,
        output in_rdy, out_vld, out_ch, out_sid, out_data, cnt
    );

    modport master (
        output in_vld, in_sid, in_data, flush, out_rdy,
        input  in_rdy, out_vld, out_ch, out_sid, out_data, cnt
    );

endinterface

// File: rtl/nou_req_fifo.sv
// Single-channel request FIFO, any DEPTH >= 1 (pointers wrap explicitly).
// Ports: push/pop/flush controls, din, full/empty/count status, head entry.
module nou_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem[rd_ptr];

    // No bypass: a full FIFO refuses a push even when popped this cycle.
    // Flush overrides both push and pop.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (do_push && !do_pop)
                cnt_q <= cnt_q + CW'(1);
            else if (!do_push && do_pop)
                cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/nou_req_queue.sv
// NOU request queue: one FIFO per channel merged by a locked round-robin
// arbiter. Ports: clk, rst (sync, active-high), bus (nou_req_queue_if.slave).
module nou_req_queue
    import nou_req_pkg::*;
#(
    parameter int NUM_CH = NOU_REQ_NUM_CH,
    parameter int DATA_W = NOU_REQ_DATA_W,
    parameter int SID_W  = NOU_SID_WIDTH,
    parameter int DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rst,
    nou_req_queue_if.slave  bus
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNW = $clog2(DEPTH + 1);
    localparam int EW  = SID_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    arb_state_e       state, state_nxt;
    logic [CHW-1:0]   rr_ptr, rr_nxt;
    logic [CHW-1:0]   lock_ch, lock_nxt;
    logic [CHW-1:0]   pick;
    logic [CHW-1:0]   out_ch;
    logic             found;
    logic             any;
    logic             lock_vld;
    logic             fire;

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [EW-1:0]     head  [NUM_CH];
    logic [CNW-1:0]    count [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign push[g] = bus.in_vld[g] && !full[g] && !bus.flush[g];
        assign pop[g]  = fire && (out_ch == CHW'(g));

        nou_req_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (EW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (pop[g]),
            .flush (bus.flush[g]),
            .din   ({bus.in_sid[g*SID_W +: SID_W],
                     bus.in_data[g*DATA_W +: DATA_W]}),
            .full  (full[g]),
            .empty (empty[g]),
            .count (count[g]),
            .head  (head[g])
        );

        assign bus.in_rdy[g]             = !full[g];
        assign bus.cnt[g*CNW +: CNW]     = count[g];
    end

    // First non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && !empty[(int'(rr_ptr) + i) % NUM_CH]) begin
                found = 1'b1;
                pick  = CHW'((int'(rr_ptr) + i) % NUM_CH);
            end
        end
    end

    assign any      = !(&empty);
    assign lock_vld = (state == HOLD);
    assign out_ch   = lock_vld ? lock_ch : pick;
    assign fire     = any && bus.out_rdy;

    assign bus.out_vld = any;
    assign bus.out_ch  = out_ch;
    assign {bus.out_sid, bus.out_data} = any ? head[out_ch] : '0;

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_ch;
        rr_nxt    = rr_ptr;
        if (fire)
            rr_nxt = (out_ch == CHW'(NUM_CH - 1)) ? '0 : out_ch + CHW'(1);
        unique case (state)
            IDLE, OFFER: begin
                // A stalled offer is frozen unless that channel is flushing.
                if (any && !bus.out_rdy && !bus.flush[out_ch]) begin
                    state_nxt = HOLD;
                    lock_nxt  = out_ch;
                end else begin
                    state_nxt = any ? OFFER : IDLE;
                end
            end
            HOLD: begin
                if (fire || bus.flush[lock_ch])
                    state_nxt = any ? OFFER : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_nxt;
            lock_ch <= lock_nxt;
        end
    end

endmodule

// File: tb/tb_nou_req_queue.sv
// Bench for nou_req_queue: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_nou_req_queue;

    localparam int N  = 5;
    localparam int DW = 96;
    localparam int SW = 8;
    localparam int D  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    nou_req_queue_if #(.NUM_CH(N), .DATA_W(DW), .SID_W(SW), .DEPTH(D)) bus ();
    nou_req_queue_if #(.NUM_CH(1), .DATA_W(DW), .SID_W(SW), .DEPTH(3)) b ();

    nou_req_queue #(.NUM_CH(N), .DATA_W(DW), .SID_W(SW), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    nou_req_queue #(.NUM_CH(1), .DATA_W(DW), .SID_W(SW), .DEPTH(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    logic [N-1:0]  vld;
    logic [N-1:0]  fl;
    logic          ordy;
    logic [SW-1:0] sid [N];
    logic [DW-1:0] dat [N];

    always_comb begin
        bus.in_vld  = vld;
        bus.flush   = fl;
        bus.out_rdy = ordy;
        bus.in_sid  = '0;
        bus.in_data = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_sid[i*SW +: SW]  = sid[i];
            bus.in_data[i*DW +: DW] = dat[i];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: per-channel queues, rotating priority, stall lock.
    typedef struct {
        logic [SW-1:0] s;
        logic [DW-1:0] d;
    } ent_t;

    ent_t m_q [N][$];
    int   m_rr   = 0;
    bit   m_lk   = 1'b0;
    int   m_lkch = 0;

    function automatic int m_pick();
        if (m_lk) return m_lkch;
        for (int i = 0; i < N; i++)
            if (m_q[(m_rr + i) % N].size() > 0) return (m_rr + i) % N;
        return -1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                int c;
                logic [N-1:0]   er;
                logic [2*N-1:0] ec;
                c = m_pick();
                for (int i = 0; i < N; i++) begin
                    er[i]       = (m_q[i].size() < D);
                    ec[i*2 +: 2] = 2'(m_q[i].size());
                end
                chk("m_out_vld", 128'(bus.out_vld), 128'(c >= 0));
                chk("m_in_rdy", 128'(bus.in_rdy), 128'(er));
                chk("m_cnt", 128'(bus.cnt), 128'(ec));
                if (c >= 0) begin
                    chk("m_out_ch", 128'(bus.out_ch), 128'(c));
                    chk("m_out_sid", 128'(bus.out_sid), 128'(m_q[c][0].s));
                    chk("m_out_data", 128'(bus.out_data), 128'(m_q[c][0].d));
                end
            end
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < N; i++) m_q[i].delete();
                m_rr = 0;
                m_lk = 1'b0;
            end else begin
                int c;
                int sz [N];
                c = m_pick();
                for (int i = 0; i < N; i++) sz[i] = m_q[i].size();
                if (c >= 0 && ordy) begin
                    void'(m_q[c].pop_front());
                    m_rr = (c + 1) % N;
                end
                for (int i = 0; i < N; i++) begin
                    if (fl[i]) m_q[i].delete();
                    else if (vld[i] && sz[i] < D)
                        m_q[i].push_back('{s: sid[i], d: dat[i]});
                end
                m_lk   = (c >= 0) && !ordy && !fl[c];
                m_lkch = c;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] cnt_of(input int i);
        return bus.cnt[i*2 +: 2];
    endfunction

    int rr_exp [6] = '{0, 1, 4, 0, 1, 4};

    initial begin
        vld  = '0;
        fl   = '0;
        ordy = 1'b0;
        for (int i = 0; i < N; i++) begin
            sid[i] = '0;
            dat[i] = '0;
        end
        b.in_vld  = 1'b0;
        b.in_sid  = '0;
        b.in_data = '0;
        b.flush   = 1'b0;
        b.out_rdy = 1'b0;

        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_rdy", 128'(bus.in_rdy), 128'h1f);
        chk("rst_out_vld", 128'(bus.out_vld), 128'h0);
        chk("rst_cnt", 128'(bus.cnt), 128'h0);
        chk("rst_out_ch", 128'(bus.out_ch), 128'h0);
        chk("rst_out_data", 128'(bus.out_data), 128'h0);

        // Single push, one-cycle latency
        ordy = 1'b1;
        vld[2] = 1'b1; sid[2] = 8'd3; dat[2] = 96'hABC;
        step();
        vld = '0;
        chk("single_vld", 128'(bus.out_vld), 128'h1);
        chk("single_ch", 128'(bus.out_ch), 128'd2);
        chk("single_sid", 128'(bus.out_sid), 128'd3);
        chk("single_data", 128'(bus.out_data), 128'hABC);
        chk("single_cnt", 128'(cnt_of(2)), 128'd1);
        step();
        chk("single_cnt_after", 128'(cnt_of(2)), 128'd0);
        chk("single_vld_after", 128'(bus.out_vld), 128'h0);

        // Fill ch0, backpressure, no bypass
        ordy = 1'b0;
        vld[0] = 1'b1; sid[0] = 8'd1; dat[0] = 96'h10;
        step();
        chk("full_cnt1", 128'(cnt_of(0)), 128'd1);
        chk("full_rdy1", 128'(bus.in_rdy[0]), 128'h1);
        dat[0] = 96'h11;
        step();
        chk("full_cnt2", 128'(cnt_of(0)), 128'd2);
        chk("full_rdy2", 128'(bus.in_rdy[0]), 128'h0);
        dat[0] = 96'h12;
        step();
        chk("full_refused", 128'(cnt_of(0)), 128'd2);
        chk("full_head", 128'(bus.out_data), 128'h10);
        ordy = 1'b1;
        step();
        chk("nobypass_cnt", 128'(cnt_of(0)), 128'd1);
        chk("nobypass_head", 128'(bus.out_data), 128'h11);
        ordy = 1'b0;
        step();
        chk("third_acc", 128'(cnt_of(0)), 128'd2);
        vld = '0;
        ordy = 1'b1;
        step();
        chk("drain_head", 128'(bus.out_data), 128'h12);
        step();
        chk("drain_vld", 128'(bus.out_vld), 128'h0);

        // Reset mid-operation discards entries
        ordy = 1'b0;
        vld[3] = 1'b1; dat[3] = 96'h77;
        step();
        vld = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_cnt", 128'(bus.cnt), 128'h0);
        chk("midrst_vld", 128'(bus.out_vld), 128'h0);

        // Round-robin over ch0, ch1, ch4
        vld = 5'b10011;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) dat[c] = DW'(256 + c * 16 + k);
            step();
        end
        vld = '0;
        ordy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_ch%0d", k), 128'(bus.out_ch), 128'(rr_exp[k]));
            step();
        end
        chk("rr_done", 128'(bus.out_vld), 128'h0);

        // Lock stability
        ordy = 1'b0;
        vld[3] = 1'b1; sid[3] = 8'd3; dat[3] = 96'h33;
        step();
        vld = '0;
        vld[0] = 1'b1; dat[0] = 96'h0A;
        step();
        vld = '0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lock_ch%0d", k), 128'(bus.out_ch), 128'd3);
            chk($sformatf("lock_data%0d", k), 128'(bus.out_data), 128'h33);
            step();
        end
        ordy = 1'b1;
        chk("lock_rel3", 128'(bus.out_ch), 128'd3);
        step();
        chk("lock_then0", 128'(bus.out_ch), 128'd0);
        chk("lock_then0_d", 128'(bus.out_data), 128'h0A);
        step();
        chk("lock_done", 128'(bus.out_vld), 128'h0);

        // Flush a locked channel holding two entries
        ordy = 1'b0;
        vld = 5'b10010; dat[1] = 96'h51; dat[4] = 96'h54;
        step();
        vld = 5'b00010; dat[1] = 96'h52;
        step();
        vld = '0;
        chk("fl_pre_ch", 128'(bus.out_ch), 128'd1);
        fl[1] = 1'b1;
        step();
        fl = '0;
        chk("fl_cnt1", 128'(cnt_of(1)), 128'd0);
        chk("fl_next_vld", 128'(bus.out_vld), 128'h1);
        chk("fl_next_ch", 128'(bus.out_ch), 128'd4);
        chk("fl_next_data", 128'(bus.out_data), 128'h54);
        ordy = 1'b1;
        step();
        chk("fl_drained", 128'(bus.out_vld), 128'h0);

        // Flush concurrent with push
        ordy = 1'b0;
        vld[1] = 1'b1; fl[1] = 1'b1; dat[1] = 96'h99;
        step();
        vld = '0; fl = '0;
        chk("flpush_cnt", 128'(cnt_of(1)), 128'd0);
        chk("flpush_vld", 128'(bus.out_vld), 128'h0);

        // Flush concurrent with a handshake on the offered channel
        vld[2] = 1'b1; dat[2] = 96'h22;
        step();
        vld = '0;
        ordy = 1'b1; fl[2] = 1'b1;
        chk("flpop_vld", 128'(bus.out_vld), 128'h1);
        step();
        fl = '0;
        chk("flpop_cnt", 128'(cnt_of(2)), 128'd0);
        chk("flpop_after", 128'(bus.out_vld), 128'h0);

        // DEPTH=3 wrap: order preserved across pointer wraps
        b.out_rdy = 1'b0;
        b.in_vld  = 1'b1;
        b.in_data = 96'd100;
        step();
        b.in_data = 96'd101;
        step();
        chk("wrap_pre_cnt", 128'(b.cnt), 128'd2);
        b.out_rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            b.in_data = DW'(102 + k);
            chk($sformatf("wrap_data%0d", k), 128'(b.out_data), 128'(100 + k));
            chk($sformatf("wrap_cnt%0d", k), 128'(b.cnt), 128'd2);
            step();
        end
        b.in_vld = 1'b0;
        chk("wrap_tail0", 128'(b.out_data), 128'd107);
        step();
        chk("wrap_tail1", 128'(b.out_data), 128'd108);
        step();
        chk("wrap_empty", 128'(b.out_vld), 128'h0);

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nou_req_queue.md
# nou_req_queue

Parametrised successor to the NOU decode-stage request registers. It replaces the single-entry, always-overwrite register per request type with a per-channel FIFO of configurable depth, a valid/ready handshake on every channel, and a locked round-robin arbiter. The arbiter merges all channels onto one output stream toward the NOU execution stage. It sits between the command decoder and the buffer/whitelist/send engines.

## Interface
- `NUM_CH`, default 5: number of request channels (0 IRR, 1 BRR, 2 PWRR, 3 SPIDR, 4 SPRR). Legal range 1..16.
- `DATA_W`, default 96: packed payload width. Each channel's fields are zero-extended to this width by the decoder.
- `SID_W`, default `NOU_SID_WIDTH`: stream ID width.
- `DEPTH`, default 2: entries per channel FIFO. Legal range 1..16. Need not be a power of 2.
- `clk`, in, 1: clock. Single clock domain.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_vld`, in, NUM_CH: per-channel request valid.
- `in_rdy`, out, NUM_CH: per-channel ready. `in_rdy[i] = !full[i]`, registered-state only.
- `in_sid`, in, NUM_CH*SID_W: per-channel SID. Channel i occupies bits `[i*SID_W +: SID_W]`.
- `in_data`, in, NUM_CH*DATA_W: per-channel payload, same packing.
- `flush`, in, NUM_CH: per-channel synchronous clear.
- `out_vld`, out, 1: merged request valid.
- `out_rdy`, in, 1: downstream accept.
- `out_ch`, out, `$clog2(NUM_CH)` (min 1): channel index of the current output.
- `out_sid`, out, SID_W: SID of the current output.
- `out_data`, out, DATA_W: payload of the current output.
- `cnt`, out, NUM_CH*`$clog2(DEPTH+1)`: per-channel occupancy.

## Operation
- **Push.** Channel i pushes when `in_vld[i] && in_rdy[i]`. `{sid, data}` is written at the write pointer.
  - If the channel is full, `in_vld` is simply held; nothing is dropped.
  - There is no bypass: a push into a full FIFO is refused even if a pop occurs in the same cycle.
- **Pop.** Occurs on `out_vld && out_rdy`. It pops exactly the head of channel `out_ch`.
- **Pointers.** Read and write pointers wrap from DEPTH-1 to 0, which is correct for non-power-of-2 DEPTH. The count is updated as +1, -1, or unchanged when a push and pop coincide.
- **Arbitration.** Round-robin over non-empty channels.
  - Search starts at `rr_ptr`; the first non-empty channel wins.
  - After a pop from channel k, `rr_ptr = (k+1) mod NUM_CH`.
- **Grant lock.** When `out_vld && !out_rdy`, the current grant is locked in `lock_vld`/`lock_ch`.
  - While locked, `out_ch`, `out_sid` and `out_data` are stable until popped, even if other channels fill.
  - The lock clears on pop or on `flush[lock_ch]`.
- **Flush.** `flush[i]` clears channel i's pointers and count next cycle.
  - A push on channel i in the same cycle is discarded.
  - If `out_ch == i` in that cycle, `out_vld` is still asserted that cycle; a handshake then is taken as a pop of that entry, and the flush wins for the next state.
  - The lock is released.
- **States.** Arbiter FSM: `IDLE` (no non-empty channel), `OFFER` (unlocked, out_vld), `HOLD` (locked).
  - IDLE→OFFER when any channel is non-empty.
  - OFFER→HOLD when `!out_rdy`.
  - HOLD→OFFER/IDLE on pop or flush of `lock_ch`.

## Timing
- Reset values (after a cycle with `rst=1`): all counts 0, `in_rdy` all 1, `out_vld` 0, `out_ch`/`out_sid`/`out_data` 0, `rr_ptr` 0, lock clear.
- Reset mid-operation discards all entries and the lock in one cycle.
- Latency: push at cycle T into an empty system gives `out_vld=1` at T+1. Throughput is one pop per cycle.
- `in_rdy[i]` falls the cycle after the push that fills the FIFO and rises the cycle after a pop from a full FIFO.
- `out_vld` and `out_ch` depend only on registered state. The output data path is a mux of FIFO heads and is combinational from registers.

## Structure
- Package `nou_req_pkg` holds:
  - the channel index enum (`CH_IRR`..`CH_SPRR`) and `NOU_REQ_NUM_CH`;
  - the `DATA_W` default, derived as the widest packed request;
  - pack/unpack functions per request type.
- Sub-module `nou_req_fifo` (DEPTH, WIDTH): push, pop, flush, full, empty, count, head.
  - It is instantiated NUM_CH times via generate.
  - The arbiter, lock and FSM live in the top.

## Test plan
- **Reset:** after `rst`, `in_rdy=5'b11111`, `out_vld=0`, all `cnt=0`.
- **Single push:** push ch2 `sid=3`, `data=0xABC` at T → at T+1 `out_vld=1`, `out_ch=2`, `out_sid=3`, `out_data=0xABC`. With `out_rdy=1`, `cnt[2]` returns to 0 at T+2.
- **Full/backpressure, DEPTH=2:** three back-to-back pushes on ch0 with `out_rdy=0` → first two accepted, `in_rdy[0]=0` from the cycle after the second, `cnt[0]=2`. The third is accepted only after one pop.
- **Round-robin fairness:** ch0, ch1 and ch4 each hold 2 entries, `out_rdy=1` → `out_ch` sequence 0,1,4,0,1,4.
- **Lock stability:** ch3 offered with `out_rdy=0`, then push ch0 → `out_ch` stays 3 for 4 stalled cycles. On release, 3 pops, then 0.
- **Flush corner cases:**
  - Flush ch1 while it is locked with 2 entries → `cnt[1]=0` next cycle, lock released, next non-empty channel offered.
  - Flush concurrent with a push on ch1 → entry discarded.
  - DEPTH=3 wrap: 7 push/pop cycles on one channel preserve data order.
